// File: rtl/mlu_seq.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs long ops for a fixed
// per-class latency, and supports accumulate modes, flush cancel and D-stage stall.
module mlu_seq #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       mlu_op,
  input  logic [2:0]       mlu_out,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  input  logic             use_d,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTHI  = 5'd5;
  localparam logic [4:0] OP_MTLO  = 5'd6;
  localparam logic [4:0] OP_MADD  = 5'd7;
  localparam logic [4:0] OP_MADDU = 5'd8;
  localparam logic [4:0] OP_MSUB  = 5'd9;
  localparam logic [4:0] OP_MSUBU = 5'd10;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [4:0]         op_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;

  logic [2*WIDTH-1:0] prod_signed_s;
  logic [2*WIDTH-1:0] prod_unsigned_s;
  logic [2*WIDTH-1:0] result_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic               wr_en_s;

  function automatic logic is_long_op(input logic [4:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Operands widened to 2*WIDTH so the truncated product is exact for both signednesses.
  assign prod_signed_s   = {{WIDTH{op_a_r[WIDTH-1]}}, op_a_r} * {{WIDTH{op_b_r[WIDTH-1]}}, op_b_r};
  assign prod_unsigned_s = {{WIDTH{1'b0}}, op_a_r} * {{WIDTH{1'b0}}, op_b_r};

  // Quotient/remainder; the most-negative / -1 overflow case is pinned explicitly.
  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    if (op_r == OP_DIV) begin
      if ((op_a_r == MIN_NEG) && (op_b_r == {WIDTH{1'b1}})) begin
        quot_s = MIN_NEG;
        rem_s  = '0;
      end else begin
        quot_s = $signed(op_a_r) / $signed(op_b_r);
        rem_s  = $signed(op_a_r) % $signed(op_b_r);
      end
    end else begin
      quot_s = op_a_r / op_b_r;
      rem_s  = op_a_r % op_b_r;
    end
  end

  // Final {hi,lo} value for the latched op; a zero divisor suppresses the write.
  always_comb begin
    result_s = {hi_r, lo_r};
    wr_en_s  = 1'b1;
    case (op_r)
      OP_MULT:  result_s = prod_signed_s;
      OP_MULTU: result_s = prod_unsigned_s;
      OP_MADD:  result_s = acc_r + prod_signed_s;
      OP_MADDU: result_s = acc_r + prod_unsigned_s;
      OP_MSUB:  result_s = acc_r - prod_signed_s;
      OP_MSUBU: result_s = acc_r - prod_unsigned_s;
      OP_DIV, OP_DIVU: begin
        if (op_b_r == '0) begin
          wr_en_s = 1'b0;
        end else begin
          result_s = {rem_s, quot_s};
        end
      end
      default:  wr_en_s = 1'b0;
    endcase
  end

  // Control FSM, latency counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
      op_r    <= 5'd0;
      op_a_r  <= '0;
      op_b_r  <= '0;
      acc_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !cancel) begin
            if (is_long_op(mlu_op)) begin
              op_r    <= mlu_op;
              op_a_r  <= rs_val;
              op_b_r  <= rt_val;
              acc_r   <= {hi_r, lo_r};
              cnt_r   <= is_div_op(mlu_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else if (mlu_op == OP_MTHI) begin
              hi_r <= rs_val;
            end else if (mlu_op == OP_MTLO) begin
              lo_r <= rs_val;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            if (wr_en_s) begin
              {hi_r, lo_r} <= result_s;
            end else begin
              {hi_r, lo_r} <= {hi_r, lo_r};
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Read mux onto the result bus.
  always_comb begin
    case (mlu_out)
      3'd1:    res = hi_r;
      3'd2:    res = lo_r;
      default: res = '0;
    endcase
  end

  assign stall = use_d & (busy_r | (start & is_long_op(mlu_op) & ~cancel));
  assign busy  = busy_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mlu_seq.sv
// Self-checking bench for mlu_seq: scoreboard of expected {hi,lo} pushed at
// start and popped when busy falls, plus a WIDTH=16 / MULT_LAT=1 instance.
module tb_mlu_seq;

  logic        clk = 1'b0;
  logic        reset, start, cancel, use_d;
  logic [4:0]  mlu_op;
  logic [2:0]  mlu_out;
  logic [31:0] rs_val, rt_val, res, hi, lo;
  logic        busy, stall;

  logic        start16, cancel16, use_d16, busy16, stall16;
  logic [4:0]  op16;
  logic [2:0]  out16;
  logic [15:0] a16, b16, res16, hi16, lo16;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mlu_seq dut (
    .clk(clk), .reset(reset), .start(start), .mlu_op(mlu_op), .mlu_out(mlu_out),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel), .use_d(use_d),
    .busy(busy), .stall(stall), .res(res), .hi(hi), .lo(lo)
  );

  mlu_seq #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(10)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mlu_op(op16), .mlu_out(out16),
    .rs_val(a16), .rt_val(b16), .cancel(cancel16), .use_d(use_d16),
    .busy(busy16), .stall(stall16), .res(res16), .hi(hi16), .lo(lo16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one long op, count busy cycles, then compare against the scoreboard.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat, input int inj);
    logic [63:0] e;
    int n;
    exp_q.push_back(exp);
    start = 1'b1; mlu_op = op; rs_val = a; rt_val = b;
    #1;
    chk({name, ".stall_start"}, 64'(stall), 64'(use_d));
    tick;
    start = 1'b0; mlu_op = 5'd0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      chk({name, ".stall_busy"}, 64'(stall), 64'(use_d));
      if (n == inj) begin
        start = 1'b1; mlu_op = 5'd5; rs_val = 32'hDEADBEEF;
      end
      tick;
      start = 1'b0; mlu_op = 5'd0;
    end
    chk({name, ".busy_cycles"}, 64'(n), 64'(lat));
    chk({name, ".stall_end"}, 64'(stall), 64'd0);
    e = exp_q.pop_front();
    chk({name, ".hi"}, 64'(hi), 64'(e[63:32]));
    chk({name, ".lo"}, 64'(lo), 64'(e[31:0]));
    mlu_out = 3'd1; #1;
    chk({name, ".res_hi"}, 64'(res), 64'(e[63:32]));
    mlu_out = 3'd2; #1;
    chk({name, ".res_lo"}, 64'(res), 64'(e[31:0]));
    mlu_out = 3'd0; #1;
    chk({name, ".res_none"}, 64'(res), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] e;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; use_d = 1'b0;
    mlu_op = 5'd0; mlu_out = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    start16 = 1'b0; cancel16 = 1'b0; use_d16 = 1'b0; op16 = 5'd0;
    out16 = 3'd1; a16 = 16'd0; b16 = 16'd0;
    tick; tick;
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.res", 64'(res), 64'd0);
    chk("rst.busy16", 64'(busy16), 64'd0);
    reset = 1'b1;
    tick;

    run_op("mult",   5'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 0);
    run_op("multu",  5'd2, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5, 0);
    run_op("div",    5'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 0);
    run_op("divu0",  5'd4, 32'd7, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 10, 0);
    run_op("divovf", 5'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 0);

    start = 1'b1; mlu_op = 5'd5; rs_val = 32'h12345678;
    tick;
    start = 1'b0; mlu_op = 5'd0;
    chk("mthi.busy", 64'(busy), 64'd0);
    chk("mthi.hi", 64'(hi), 64'h12345678);
    chk("mthi.lo", 64'(lo), 64'h80000000);
    start = 1'b1; mlu_op = 5'd6; rs_val = 32'd1;
    tick;
    start = 1'b0; mlu_op = 5'd0;
    chk("mtlo.lo", 64'(lo), 64'd1);
    chk("mtlo.hi", 64'(hi), 64'h12345678);

    run_op("madd",  5'd7,  32'd2, 32'd3, 64'h12345678_00000007, 5, 0);
    run_op("msubu", 5'd10, 32'd1, 32'd8, 64'h12345677_FFFFFFFF, 5, 0);
    run_op("maddu", 5'd8,  32'hFFFFFFFF, 32'd2, 64'h12345679_FFFFFFFD, 5, 0);
    run_op("msub",  5'd9,  32'hFFFFFFFF, 32'd2, 64'h12345679_FFFFFFFF, 5, 0);
    run_op("divu",  5'd4,  32'd100, 32'd7, 64'h00000002_0000000E, 10, 0);

    use_d = 1'b1;
    run_op("stall", 5'd1, 32'h10, 32'h10, 64'h00000000_00000100, 5, 0);
    use_d = 1'b0;

    // Cancel two cycles into a div: result must never land.
    start = 1'b1; mlu_op = 5'd3; rs_val = 32'd100; rt_val = 32'd7;
    tick;
    start = 1'b0; mlu_op = 5'd0;
    chk("cancel.busy1", 64'(busy), 64'd1);
    tick;
    chk("cancel.busy2", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    chk("cancel.busy_off", 64'(busy), 64'd0);
    chk("cancel.hi", 64'(hi), 64'd0);
    chk("cancel.lo", 64'(lo), 64'h100);
    repeat (12) tick;
    chk("cancel.hi_late", 64'(hi), 64'd0);
    chk("cancel.lo_late", 64'(lo), 64'h100);

    use_d = 1'b1;
    start = 1'b1; mlu_op = 5'd1; rs_val = 32'd3; rt_val = 32'd3; cancel = 1'b1;
    #1;
    chk("cstart.stall", 64'(stall), 64'd0);
    tick;
    start = 1'b0; mlu_op = 5'd0; cancel = 1'b0;
    chk("cstart.busy", 64'(busy), 64'd0);
    tick;
    chk("cstart.busy2", 64'(busy), 64'd0);
    chk("cstart.lo", 64'(lo), 64'h100);
    use_d = 1'b0;
    start = 1'b1; mlu_op = 5'd5; rs_val = 32'h0000AAAA; cancel = 1'b1;
    tick;
    start = 1'b0; mlu_op = 5'd0; cancel = 1'b0;
    chk("cmthi.hi", 64'(hi), 64'd0);

    run_op("busyign", 5'd1, 32'd3, 32'd4, 64'h00000000_0000000C, 5, 2);

    // Reset during busy cycle 3 of a mult, with a start held through reset.
    start = 1'b1; mlu_op = 5'd1; rs_val = 32'd7; rt_val = 32'd7;
    tick;
    start = 1'b0; mlu_op = 5'd0;
    tick; tick;
    chk("rstmid.busy3", 64'(busy), 64'd1);
    reset = 1'b0; start = 1'b1; mlu_op = 5'd1; rs_val = 32'd9; rt_val = 32'd9;
    tick;
    chk("rstmid.hi", 64'(hi), 64'd0);
    chk("rstmid.lo", 64'(lo), 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    tick;
    reset = 1'b1; start = 1'b0; mlu_op = 5'd0;
    tick;
    chk("rstmid.busy_after", 64'(busy), 64'd0);
    chk("rstmid.lo_after", 64'(lo), 64'd0);

    // Narrow instance, single-cycle multiply.
    exp_q.push_back(64'h00000000_FFFF0000);
    start16 = 1'b1; op16 = 5'd1; a16 = 16'h8000; b16 = 16'h0002;
    tick;
    start16 = 1'b0; op16 = 5'd0;
    n = 0;
    while (busy16 && n < 64) begin
      n++;
      tick;
    end
    e = exp_q.pop_front();
    chk("w16.busy_cycles", 64'(n), 64'd1);
    chk("w16.hi", 64'(hi16), 64'(e[31:16]));
    chk("w16.lo", 64'(lo16), 64'(e[15:0]));
    chk("w16.res", 64'(res16), 64'(e[31:16]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
